// File: rtl/kmap_nibble_rx.sv
// One-wire receiver for the 4-input K-map stage.
// Each frame is start(0), x[1..4], odd parity, stop(1). Bad frames are flagged and counted, and x keeps its last good word.
module kmap_nibble_rx #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             in,
    output logic [4:1]       x,
    output logic             x_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_idx;
    logic [3:0]       r_shadow;
    logic             r_par_ok;
    logic             r_good_p;
    logic             r_bad_p;
    logic [4:1]       r_x;
    logic             r_x_valid;
    logic             r_frame_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_shift;
    logic             w_par_smp;
    logic             w_good;
    logic             w_bad;

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and frame-decision decode
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_par_smp   = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!in) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_shift = 1'b1;
                if (r_idx == 2'd3) begin
                    w_state_nxt = PARITY;
                end
            end
            PARITY: begin
                w_par_smp   = 1'b1;
                w_state_nxt = STOP;
            end
            STOP: begin
                // A missing stop bit overrides whatever the parity check said.
                if (in) begin
                    w_good      = r_par_ok;
                    w_bad       = !r_par_ok;
                    w_state_nxt = IDLE;
                end else begin
                    w_bad       = 1'b1;
                    w_state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (in) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: the shadow word, the parity result, and the result stage one cycle behind the stop bit.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx       <= 2'd0;
            r_shadow    <= 4'h0;
            r_par_ok    <= 1'b0;
            r_good_p    <= 1'b0;
            r_bad_p     <= 1'b0;
            r_x         <= 4'h0;
            r_x_valid   <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_good_p <= w_good;
            r_bad_p  <= w_bad;

            if (r_state == IDLE) begin
                r_idx <= 2'd0;
            end else if (w_shift) begin
                r_idx <= r_idx + 2'd1;
            end

            if (w_shift) begin
                r_shadow[r_idx] <= in;
            end

            if (w_par_smp) begin
                r_par_ok <= ^{r_shadow, in};
            end

            // The shadow word is still intact here: the next frame's data bits cannot arrive before the following edge.
            r_x_valid   <= r_good_p;
            r_frame_err <= r_bad_p;
            if (r_good_p) begin
                r_x <= r_shadow;
            end
            if (r_bad_p && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: doc/kmap_nibble_rx.md
# kmap_nibble_rx

- Serial front end for the 4-input K-map function stage.
- Deserialises framed 4-bit words from a one-wire line and checks odd parity and stop bit.
- On a good frame it presents the word on `x[4:1]` and holds it until the next good frame; downstream combinational logic computes `f` from it.
- Bad frames are flagged and counted, and never disturb `x`.

## Interface
Parameters:
- `CNT_W`, default 8: width of the saturating frame-error counter.

Ports:
- `clk`, input, 1: single clock, all state updates on posedge.
- `aresetn`, input, 1: asynchronous, active-low reset.
- `in`, input, 1: serial line, idles high, sampled once per `clk`.
- `x`, output, [4:1]: last correctly received word. Feeds the K-map stage directly.
- `x_valid`, output, 1: one-cycle pulse; `x` has just been updated.
- `frame_err`, output, 1: one-cycle pulse; a frame was rejected (parity or stop error).
- `err_cnt`, output, CNT_W: count of rejected frames, saturating at all-ones.

## Operation
- Frame format, one bit per cycle: start(0), `x[1]`, `x[2]`, `x[3]`, `x[4]`, parity, stop(1).
- Parity is odd: the four data bits plus the parity bit contain an odd number of ones.
- State machine states: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: `in==0` goes to DATA with bit index 0; otherwise stay.
  - DATA: shift `in` into a shadow register at the current index. After index 3 go to PARITY.
  - PARITY: sample the parity bit; compute ok = XOR of data and parity bits equals 1. Go to STOP.
  - STOP, `in==1`:
    - ok: load `x` from the shadow register and set `x_valid` next cycle.
    - not ok: set `frame_err` next cycle and increment `err_cnt`.
    - Either way go to IDLE.
  - STOP, `in==0`: set `frame_err` next cycle, increment `err_cnt`, go to WAIT_IDLE. A stop error takes precedence over any parity result.
  - WAIT_IDLE: stay until `in==1`, then go to IDLE. A 0 seen here is never taken as a start bit.
- The shadow register is internal. `x` changes only on a good frame.
- `err_cnt` saturates: at all-ones, further errors leave it unchanged.
- `x_valid` and `frame_err` are registered and mutually exclusive.

## Timing
- Reset (`aresetn` low, asynchronous, effective immediately):
  - State goes to IDLE and the bit index to 0.
  - `x=4'h0`, `x_valid=0`, `frame_err=0`, `err_cnt=0`, shadow register 0.
- Reset release is synchronous to the next `clk` edge.
- Reset mid-frame discards the partial frame, with no pulse and no count change.
- The start bit is sampled at edge t (IDLE sees 0).
- Data bits are sampled at t+1..t+4, parity at t+5, stop at t+6.
- `x`, `x_valid`, `frame_err` and `err_cnt` update at edge t+7. The pulse is high for exactly the cycle after t+7.
- Latency from start-bit sample to `x_valid` is 7 cycles. Minimum frame spacing is 7 cycles: back-to-back frames are allowed.
- A start bit sampled at t+7, while `x_valid` is high, begins a new frame. `x` then holds until that frame completes at t+14.
- `in` stuck at 0 after a stop error stays in WAIT_IDLE indefinitely, with no further pulses or counts.

## Test plan
- **Good frame:** reset, idle 3 cycles, then send 0,0,0,1,0,0,1 (word 4'h4, parity 0).
  - Required: `x=4'h4` and a one-cycle `x_valid` exactly 7 cycles after the start-bit edge.
  - Required: `frame_err=0`, `err_cnt=0`.
- **Back-to-back:** send 4'hB (0,1,1,0,1,0,1) immediately followed by 4'h2 (0,0,1,0,0,0,1).
  - Required: two `x_valid` pulses 7 cycles apart; `x` goes 4'hB then 4'h2.
- **Parity error:** after a good 4'h6, send 4'h7 with parity 1 (0,1,1,1,0,1,1).
  - Required: one `frame_err` pulse, `x` stays 4'h6, `err_cnt=1`, no `x_valid`.
- **Stop error:** send 4'hC with stop 0 (0,0,0,1,1,1,0), hold `in=0` for 5 cycles, then 1, then a good 4'h8 frame.
  - Required: one `frame_err`, `err_cnt` +1, and no frame start while `in` is held low.
  - Required: the 4'h8 frame is then received, giving `x=4'h8`.
- **Reset mid-frame:** pull `aresetn` low between edges during the data bits.
  - Required: outputs return to reset values immediately, with no pulses.
  - Required: a subsequent good 4'hE frame yields `x=4'hE` 7 cycles after its start bit.
- **Counter saturation:** with `CNT_W=2`, send 5 parity-error frames.
  - Required: `err_cnt` reads 1, 2, 3, 3, 3, and `frame_err` pulses all 5 times.
